// File: rtl/hwag_pkg.sv
// Shared state encoding and default widths for the crank tooth synchroniser.
package hwag_pkg;
    localparam int HWAG_TW   = 24;
    localparam int HWAG_CW   = 8;
    localparam int GAP_SHIFT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRST   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_SYNC    = 3'd4
    } hwag_state_e;
endpackage

// File: rtl/hwag_period_timer.sv
// Saturating edge-to-edge timer with a capture register holding the last period.
module hwag_period_timer
    import hwag_pkg::*;
#(
    parameter int TW = HWAG_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          restart,
    input  logic          cap_en,
    input  logic          cap_clr,
    output logic [TW-1:0] cnt,
    output logic [TW-1:0] cap,
    output logic          sat
);
    localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

    logic [TW-1:0] cnt_d, cnt_q;
    logic [TW-1:0] cap_d, cap_q;

    // Next-state for the running counter and the captured period.
    always_comb begin
        cnt_d = cnt_q;
        cap_d = cap_q;
        if (!run) begin
            cnt_d = CNT_ZERO;
        end else if (restart) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (cap_clr) begin
            cap_d = CNT_ZERO;
        end else if (cap_en) begin
            cap_d = cnt_q;
        end else begin
            cap_d = cap_q;
        end
    end

    // Timer and capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
            cap_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
            cap_q <= cap_d;
        end
    end

    assign cnt = cnt_q;
    assign cap = cap_q;
    assign sat = (cnt_q == CNT_MAX);
endmodule

// File: rtl/hwag_tooth_sync.sv
// Tooth period measurement, missing-tooth gap detection and absolute tooth index.
module hwag_tooth_sync
    import hwag_pkg::*;
#(
    parameter int TW = HWAG_TW,
    parameter int CW = HWAG_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          edge_in,
    input  logic [CW-1:0] tooth_last,
    output logic [TW-1:0] period,
    output logic [CW-1:0] tooth,
    output logic          synced,
    output logic          tooth_stb,
    output logic          gap_stb,
    output logic          err_stb,
    output logic          stall_stb
);
    localparam logic [TW-1:0] PRD_ZERO   = {TW{1'b0}};
    localparam logic [CW-1:0] TOOTH_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] TOOTH_ONE  = {{(CW-1){1'b0}}, 1'b1};

    hwag_state_e   state_d, state_q;
    logic [TW-1:0] prev_d, prev_q;
    logic [CW-1:0] tooth_d, tooth_q;
    logic          synced_d, synced_q;
    logic          tooth_stb_d, tooth_stb_q;
    logic          gap_stb_d, gap_stb_q;
    logic          err_stb_d, err_stb_q;
    logic          stall_stb_d, stall_stb_q;

    logic [TW-1:0] cur_s;
    logic          sat_s;
    logic          run_s, restart_s, cap_en_s, cap_clr_s;
    logic [TW:0]   thr_s;
    logic          gap_s;

    hwag_period_timer #(.TW(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run_s),
        .restart (restart_s),
        .cap_en  (cap_en_s),
        .cap_clr (cap_clr_s),
        .cnt     (cur_s),
        .cap     (period),
        .sat     (sat_s)
    );

    // Evaluated one bit wider so prev + prev/2 cannot wrap.
    assign thr_s = {1'b0, prev_q} + ({1'b0, prev_q} >> GAP_SHIFT);
    assign gap_s = ({1'b0, cur_s} > thr_s);

    // FSM next-state, tooth counter and strobe generation.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        tooth_d     = tooth_q;
        synced_d    = synced_q;
        tooth_stb_d = 1'b0;
        gap_stb_d   = 1'b0;
        err_stb_d   = 1'b0;
        stall_stb_d = 1'b0;
        restart_s   = 1'b0;
        cap_en_s    = 1'b0;
        cap_clr_s   = 1'b0;
        if (!ena) begin
            state_d   = ST_IDLE;
            prev_d    = PRD_ZERO;
            tooth_d   = TOOTH_ZERO;
            synced_d  = 1'b0;
            cap_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FIRST;
                ST_FIRST, ST_MEASURE, ST_SEARCH, ST_SYNC: begin
                    if (edge_in) begin
                        restart_s = 1'b1;
                        if (state_q == ST_FIRST) begin
                            state_d = ST_MEASURE;
                        end else begin
                            cap_en_s = 1'b1;
                            prev_d   = cur_s;
                            case (state_q)
                                ST_MEASURE: state_d = ST_SEARCH;
                                ST_SEARCH: begin
                                    if (gap_s) begin
                                        gap_stb_d = 1'b1;
                                        tooth_d   = TOOTH_ZERO;
                                        synced_d  = 1'b1;
                                        state_d   = ST_SYNC;
                                    end else begin
                                        state_d = ST_SEARCH;
                                    end
                                end
                                ST_SYNC: begin
                                    if (tooth_q != tooth_last) begin
                                        if (gap_s) begin
                                            err_stb_d = 1'b1;
                                            gap_stb_d = 1'b1;
                                            synced_d  = 1'b0;
                                            tooth_d   = TOOTH_ZERO;
                                            state_d   = ST_SEARCH;
                                        end else begin
                                            tooth_d     = tooth_q + TOOTH_ONE;
                                            tooth_stb_d = 1'b1;
                                        end
                                    end else begin
                                        if (gap_s) begin
                                            tooth_d     = TOOTH_ZERO;
                                            gap_stb_d   = 1'b1;
                                            tooth_stb_d = 1'b1;
                                        end else begin
                                            err_stb_d = 1'b1;
                                            synced_d  = 1'b0;
                                            state_d   = ST_SEARCH;
                                        end
                                    end
                                end
                                default: state_d = ST_IDLE;
                            endcase
                        end
                    end else if (sat_s) begin
                        // Restart the timer so a stall is reported once per saturation.
                        restart_s   = 1'b1;
                        stall_stb_d = 1'b1;
                        err_stb_d   = (state_q == ST_SYNC);
                        synced_d    = 1'b0;
                        tooth_d     = TOOTH_ZERO;
                        prev_d      = PRD_ZERO;
                        state_d     = ST_FIRST;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        run_s = (state_d != ST_IDLE);
    end

    // State, tooth index and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_q      <= PRD_ZERO;
            tooth_q     <= TOOTH_ZERO;
            synced_q    <= 1'b0;
            tooth_stb_q <= 1'b0;
            gap_stb_q   <= 1'b0;
            err_stb_q   <= 1'b0;
            stall_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            tooth_q     <= tooth_d;
            synced_q    <= synced_d;
            tooth_stb_q <= tooth_stb_d;
            gap_stb_q   <= gap_stb_d;
            err_stb_q   <= err_stb_d;
            stall_stb_q <= stall_stb_d;
        end
    end

    assign tooth     = tooth_q;
    assign synced    = synced_q;
    assign tooth_stb = tooth_stb_q;
    assign gap_stb   = gap_stb_q;
    assign err_stb   = err_stb_q;
    assign stall_stb = stall_stb_q;
endmodule

// File: tb/tb_hwag_tooth_sync.sv
// Directed bench for hwag_tooth_sync on a 60-2 wheel, run with a 12-bit timer.
module tb_hwag_tooth_sync;
    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        edge_in;
    logic [7:0]  tooth_last;
    logic [11:0] period;
    logic [7:0]  tooth;
    logic        synced, tooth_stb, gap_stb, err_stb, stall_stb;

    int n_checks = 0;
    int n_errors = 0;

    hwag_tooth_sync #(.TW(12), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .edge_in    (edge_in),
        .tooth_last (tooth_last),
        .period     (period),
        .tooth      (tooth),
        .synced     (synced),
        .tooth_stb  (tooth_stb),
        .gap_stb    (gap_stb),
        .err_stb    (err_stb),
        .stall_stb  (stall_stb)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".period"}, 32'(period), 32'd0);
        check_val({tag, ".tooth"}, 32'(tooth), 32'd0);
        check_val({tag, ".synced"}, 32'(synced), 32'd0);
        check_val({tag, ".strobes"}, 32'({tooth_stb, gap_stb, err_stb, stall_stb}), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edge strobe placed n cycles after the previous one; returns with its outputs visible.
    task automatic edge_gap(input int n);
        for (int i = 0; i < n - 1; i++) step();
        edge_in = 1'b1;
        step();
        edge_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; edge_in = 1'b0; tooth_last = 8'd57;
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("idle");

        // Acquire: first edge uncaptured, second gives the period.
        ena = 1'b1;
        edge_gap(5);
        check_val("first.period", 32'(period), 32'd0);
        edge_gap(100);
        check_val("measure.period", 32'(period), 32'd100);
        check_val("measure.synced", 32'(synced), 32'd0);
        for (int i = 0; i < 10; i++) begin
            edge_gap(100);
            check_val("search.gap", 32'(gap_stb), 32'd0);
        end
        edge_gap(300);
        check_val("acq.gap", 32'(gap_stb), 32'd1);
        check_val("acq.synced", 32'(synced), 32'd1);
        check_val("acq.tooth", 32'(tooth), 32'd0);
        check_val("acq.period", 32'(period), 32'd300);
        step();
        check_val("acq.gap_pulse", 32'(gap_stb), 32'd0);

        // Three clean revolutions.
        for (int r = 0; r < 3; r++) begin
            for (int t = 1; t <= 57; t++) begin
                edge_gap(100);
                check_val("rev.tooth", 32'(tooth), 32'(t));
                check_val("rev.tstb", 32'(tooth_stb), 32'd1);
                check_val("rev.err", 32'(err_stb), 32'd0);
            end
            edge_gap(300);
            check_val("revgap.tooth", 32'(tooth), 32'd0);
            check_val("revgap.gap", 32'(gap_stb), 32'd1);
            check_val("revgap.tstb", 32'(tooth_stb), 32'd1);
            check_val("revgap.err", 32'(err_stb), 32'd0);
            check_val("revgap.synced", 32'(synced), 32'd1);
        end

        // Unexpected gap at tooth 20, then resync on the real gap.
        for (int t = 1; t <= 20; t++) edge_gap(100);
        check_val("xgap.pre_tooth", 32'(tooth), 32'd20);
        edge_gap(300);
        check_val("xgap.err", 32'(err_stb), 32'd1);
        check_val("xgap.gap", 32'(gap_stb), 32'd1);
        check_val("xgap.synced", 32'(synced), 32'd0);
        check_val("xgap.tooth", 32'(tooth), 32'd0);
        for (int t = 0; t < 37; t++) edge_gap(100);
        check_val("xgap.search_synced", 32'(synced), 32'd0);
        edge_gap(300);
        check_val("resync.gap", 32'(gap_stb), 32'd1);
        check_val("resync.synced", 32'(synced), 32'd1);
        check_val("resync.tooth", 32'(tooth), 32'd0);
        check_val("resync.err", 32'(err_stb), 32'd0);

        // Missing gap after tooth 57.
        for (int t = 1; t <= 57; t++) edge_gap(100);
        check_val("miss.pre_tooth", 32'(tooth), 32'd57);
        edge_gap(100);
        check_val("miss.err", 32'(err_stb), 32'd1);
        check_val("miss.synced", 32'(synced), 32'd0);
        check_val("miss.gap", 32'(gap_stb), 32'd0);
        check_val("miss.tstb", 32'(tooth_stb), 32'd0);

        // Gap threshold boundary and acceleration in SEARCH.
        edge_gap(150);
        check_val("bound150.gap", 32'(gap_stb), 32'd0);
        check_val("bound150.period", 32'(period), 32'd150);
        edge_gap(100);
        check_val("accel100.gap", 32'(gap_stb), 32'd0);
        edge_gap(140);
        check_val("accel140.gap", 32'(gap_stb), 32'd0);
        edge_gap(200);
        check_val("accel200.gap", 32'(gap_stb), 32'd0);
        check_val("accel200.period", 32'(period), 32'd200);
        edge_gap(100);
        edge_gap(151);
        check_val("bound151.gap", 32'(gap_stb), 32'd1);
        check_val("bound151.synced", 32'(synced), 32'd1);

        // Timer saturation while synchronised.
        edge_gap(100);
        check_val("stall.pre_tooth", 32'(tooth), 32'd1);
        for (int i = 0; i < 4094; i++) step();
        check_val("stall.early", 32'(stall_stb), 32'd0);
        step();
        check_val("stall.stb", 32'(stall_stb), 32'd1);
        check_val("stall.err", 32'(err_stb), 32'd1);
        check_val("stall.synced", 32'(synced), 32'd0);
        check_val("stall.tooth", 32'(tooth), 32'd0);
        step();
        check_val("stall.once", 32'(stall_stb), 32'd0);
        edge_gap(50);
        check_val("stall.first_nocap", 32'(period), 32'd100);
        edge_gap(120);
        check_val("stall.second_cap", 32'(period), 32'd120);
        edge_gap(80);
        check_val("stall.third_cap", 32'(period), 32'd80);

        // ena dropped together with an edge.
        edge_gap(300);
        check_val("ena.pre_synced", 32'(synced), 32'd1);
        for (int t = 0; t < 3; t++) edge_gap(100);
        check_val("ena.pre_tooth", 32'(tooth), 32'd3);
        for (int i = 0; i < 99; i++) step();
        ena = 1'b0;
        edge_in = 1'b1;
        step();
        check_all_zero("ena_drop");
        step();
        check_all_zero("idle_edge");
        edge_in = 1'b0;

        // Asynchronous reset mid-revolution.
        ena = 1'b1;
        edge_gap(10);
        edge_gap(100);
        check_val("rst.pre_period", 32'(period), 32'd100);
        for (int t = 0; t < 3; t++) edge_gap(100);
        edge_gap(300);
        for (int t = 0; t < 5; t++) edge_gap(100);
        check_val("rst.pre_tooth", 32'(tooth), 32'd5);
        for (int i = 0; i < 50; i++) step();
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        edge_in = 1'b1;
        step();
        check_all_zero("rst_hold");
        edge_in = 1'b0;
        rst = 1'b0;
        step();
        check_all_zero("rst_release");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hwag_tooth_sync.md
Name: hwag_tooth_sync

Overview:
- Downstream of the VR capture/filter stage. Consumes its single-cycle filtered edge strobe.
- Measures the tooth period in clk cycles between consecutive edges.
- Detects the missing-tooth gap of the trigger wheel (e.g. 60-2) and keeps an absolute tooth index once synchronised.
- Feeds the later angle-generation stages with period, tooth number and sync status.

Parameters:
- TW, 24, period timer / period output width.
- CW, 8, tooth counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  block enable; 0 forces IDLE.
- edge_in  in  1  one-cycle filtered tooth edge strobe from capture stage.
- tooth_last  in  CW  index of last real tooth before gap (57 for 60-2); static while ena=1.
- period  out  TW  last measured edge-to-edge period, clk cycles.
- tooth  out  CW  current tooth index, 0 = first tooth after gap.
- synced  out  1  level, 1 while in SYNC.
- tooth_stb  out  1  one-cycle pulse per accepted edge in SYNC.
- gap_stb  out  1  one-cycle pulse when a gap period is detected.
- err_stb  out  1  one-cycle pulse on sync loss (unexpected or missing gap).
- stall_stb  out  1  one-cycle pulse when the timer saturates.

Behaviour:
- Reset (async): every register 0, including all outputs; state IDLE.
- Timer runs in every state except IDLE, saturating at all-ones.
- On an edge cycle: captured value = timer, and timer <= 1. Edges N cycles apart therefore capture N.
- All outputs are registered and update 1 cycle after the edge_in cycle.
- Gap test: cur > prev + (prev >> 1), evaluated at TW+1 bits with no overflow. cur = captured value, prev = previous captured value.
- States and transitions:
  - IDLE: timer=0, outputs held at 0. ena=1 -> FIRST.
  - FIRST: first edge -> timer restarts, nothing captured -> MEASURE.
  - MEASURE: edge -> period <= cur, prev <= cur -> SEARCH.
  - SEARCH: every edge updates period/prev. If gap -> gap_stb, tooth <= 0, synced <= 1 -> SYNC.
  - SYNC, edge with tooth != tooth_last:
    - no gap -> tooth++, tooth_stb.
    - gap -> err_stb + gap_stb, synced <= 0, tooth <= 0 -> SEARCH.
  - SYNC, edge with tooth == tooth_last:
    - gap -> tooth <= 0, gap_stb, tooth_stb.
    - no gap -> err_stb, synced <= 0 -> SEARCH.
- Timer reaching all-ones in FIRST/MEASURE/SEARCH/SYNC:
  - stall_stb pulses once.
  - synced <= 0, tooth <= 0, prev <= 0.
  - err_stb also pulses if the state was SYNC.
  - Next state FIRST.
- Simultaneous events:
  - ena=0 together with edge_in: ena wins -> IDLE, outputs cleared.
  - Saturation on the same cycle as edge_in: edge wins, normal capture of all-ones value.
- edge_in while in IDLE is ignored.
- rst asserted mid-operation: immediate clear, no strobes.
- tooth never exceeds tooth_last in SYNC. tooth_last=0 is legal: every edge is expected to be a gap.

Decomposition:
- Shared package hwag_pkg:
  - state enum (IDLE, FIRST, MEASURE, SEARCH, SYNC).
  - default widths HWAG_TW=24, HWAG_CW=8.
  - GAP_SHIFT=1 constant (1.5x threshold).
- Sub-module hwag_period_timer: saturating TW counter with clear-to-1-on-edge, capture register and sat flag.
- FSM, gap comparator and tooth counter stay in hwag_tooth_sync.

Test Plan:
- 60-2 wheel, tooth_last=57, teeth every 100 cycles, gap 300 cycles, ena=1:
  - period=100 after the 2nd edge.
  - gap_stb, synced=1 and tooth=0 after the first gap edge.
  - tooth counts 0..57.
  - next gap edge -> tooth=0, no err_stb, over 3 revolutions.
- In SYNC, an extra gap (300 cycles) at tooth 20 -> err_stb+gap_stb, synced=0, tooth=0.
  - Next expected gap resyncs with tooth=0.
- In SYNC, at tooth 57 the next period is 100 (no gap) -> err_stb, synced=0, state SEARCH.
- TW=12: in SYNC stop edges -> stall_stb 4095 cycles after the last edge, err_stb same cycle, synced=0.
  - Next 3 edges: no capture on the 1st, period on the 2nd.
- ena dropped on the same cycle as edge_in -> next cycle all outputs 0.
  - rst pulse mid-revolution -> immediate clear, no strobes.
- Acceleration 100 -> 140 -> 200 cycles/tooth, no gap -> no gap_stb.
  - Boundary: prev=100, cur=150 -> no gap; cur=151 -> gap.
